fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the memory block's instruction port.
- Owns the program counter and drives pcAddress; captures the 32-bit word returned combinationally on pcDataOutput.
- Buffers fetched words in a 2-entry queue and hands them to decode over a valid/ready handshake.
- Handles branch/jump redirects by flushing the queue.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
FIFO_DEPTH, 2, instruction queue entries; only 2 is supported.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
fetchEnable  input  1  run request; while high, fetch continues.
pcAddress  output  32  current fetch address to memory (byte address; memory decodes [15:0]).
pcDataOutput  input  32  instruction word from memory, valid in the same cycle as pcAddress.
redirect  input  1  one-cycle pulse: branch/jump taken.
redirectTarget  input  32  new PC when redirect=1.
instrValid  output  1  queue head is valid.
instrReady  input  1  decode accepts the head this cycle.
instr  output  32  queue head instruction word.
instrPc  output  32  address of the queue head instruction.
alignError  output  1  one-cycle pulse: redirectTarget[1:0] was non-zero.
busy  output  1  state != IDLE or queue non-empty.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - pc=RESET_PC, queue empty, state=IDLE.
  - instrValid=0, instr=0, instrPc=0, alignError=0, busy=0.
  - Reset mid-operation discards all queued words; no partial handshake completes.
- pcAddress = pc at all times, combinationally from the register.
- Memory read is combinational, so the fetch latency is 0 cycles to capture. Data is visible on instr one cycle after the push edge.
- pop = instrValid & instrReady.
- push = state==FETCH & !redirect & (count<2 | pop).
  - Push writes {pc, pcDataOutput} at the tail and sets pc <= pc+4.
  - Push and pop are allowed in the same cycle when full.
- State machine:
  - IDLE: no push. fetchEnable=1 -> FETCH.
  - FETCH: push when permitted. fetchEnable=0 -> DRAIN.
  - DRAIN: no push; queue keeps presenting. If fetchEnable=1 -> FETCH. Else if queue empty (after this cycle's pop) -> IDLE.
- Redirect has priority over everything in the same cycle:
  - Flush the queue (count=0, instrValid=0 next cycle); a coincident pop is discarded.
  - Set pc <= {redirectTarget[31:2], 2'b00}; no push that cycle.
  - If redirectTarget[1:0] != 0, pulse alignError for exactly the next cycle.
  - State is unchanged, except DRAIN -> IDLE because the queue is now empty.
  - Redirect is legal in IDLE; it only updates pc.
- Width and wrap rules:
  - pc arithmetic is 32-bit unsigned; 32'hFFFF_FFFC + 4 wraps to 0.
  - Memory aliases every 64 KiB; the fetch unit does not mask.
  - Queue pointers are 1-bit and wrap; count is 0..2.
- Output stability: instr and instrPc hold while instrValid=1 and instrReady=0. The decode stage may rely on this.

Decomposition:
- Package FetchTypes:
  - fetchState enum {IDLE, FETCH, DRAIN}, 2-bit logic.
  - INSTR_BYTES = 4.
  - FETCH_QUEUE_DEPTH = 2.
- Sub-module fetch_queue: 2-entry synchronous FIFO of 64-bit {pc, word}.
  - Ports: push, pop, flush, full, empty, count, head.
  - Same clk and rst.
- fetch_unit holds the PC register, FSM, and redirect and alignment logic.

Test Plan:
- Reset with RESET_PC=0, memory words 0x11111111/0x22222222/0x33333333 at 0/4/8; fetchEnable=1, instrReady=1 -> one instruction per cycle: instrPc 0,4,8 with matching instr; pcAddress advances by 4 each cycle.
- instrReady=0 for 5 cycles -> exactly 2 words queued, pc stops at 8, instr holds 0x11111111. On ready -> words 0 and 4 delivered back-to-back, then 8.
- Queue full, redirect=1 with target 0x100 while instrReady=1 -> queue flushed, no instruction accepted that cycle, next instrPc=0x100, alignError=0.
- Redirect target 0x103 -> pc=0x100, alignError high for exactly one cycle.
- Assert rst while the queue holds 2 entries and state=FETCH -> instrValid=0 and pcAddress=RESET_PC immediately, without waiting for a clock edge. After release, fetch restarts from RESET_PC.
- Drain and wrap:
  - Drop fetchEnable with 2 entries queued -> both delivered, busy falls, state=IDLE.
  - Redirect to 0xFFFFFFFC, then fetch -> next pc is 0x00000000.

Source files
------------

// File: rtl/FetchTypes.sv
// Shared types and constants for the instruction-fetch stage and its queue.
package FetchTypes;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetchState;

  localparam int unsigned INSTR_BYTES       = 4;
  localparam int unsigned FETCH_QUEUE_DEPTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of {pc, word} pairs between the fetch PC and decode.
module fetch_queue
  import FetchTypes::*;
#(
  parameter int DEPTH = FETCH_QUEUE_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t pushData,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t r_mem [FETCH_QUEUE_DEPTH];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         w_push;
  logic         w_pop;

  assign full  = (r_count == 2'(DEPTH));
  assign empty = (r_count == 2'd0);
  assign count = r_count;
  assign head  = r_mem[r_rd_ptr];

  // Push while full is only legal when a pop frees the head slot this cycle.
  assign w_push = push & ~flush & (~full | pop);
  assign w_pop  = pop & ~flush & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= pushData;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, feeds a 2-entry queue from the combinational
// instruction port and hands words to decode over valid/ready.
module fetch_unit
  import FetchTypes::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetchEnable,
  output logic [31:0] pcAddress,
  input  logic [31:0] pcDataOutput,
  input  logic        redirect,
  input  logic [31:0] redirectTarget,
  output logic        instrValid,
  input  logic        instrReady,
  output logic [31:0] instr,
  output logic [31:0] instrPc,
  output logic        alignError,
  output logic        busy
);

  fetchState    r_state;
  fetchState    w_state_nxt;
  logic [31:0]  r_pc;
  logic         r_align_err;

  logic         w_q_full;
  logic         w_q_empty;
  logic [1:0]   w_q_count;
  fetch_entry_t w_q_head;
  fetch_entry_t w_q_wdata;

  logic         w_pop;
  logic         w_q_pop;
  logic         w_push;
  logic         w_empty_after;

  assign pcAddress  = r_pc;
  assign alignError = r_align_err;
  assign instrValid = ~w_q_empty;
  assign instr      = w_q_empty ? 32'd0 : w_q_head.word;
  assign instrPc    = w_q_empty ? 32'd0 : w_q_head.pc;
  assign busy       = (r_state != IDLE) | ~w_q_empty;

  // A redirect flushes the queue, so a handshake coincident with it is dropped.
  assign w_pop         = instrValid & instrReady;
  assign w_q_pop       = w_pop & ~redirect;
  assign w_push        = (r_state == FETCH) & ~redirect & (~w_q_full | w_pop);
  assign w_empty_after = w_q_empty | ((w_q_count == 2'd1) & w_q_pop);
  assign w_q_wdata     = '{pc: r_pc, word: pcDataOutput};

  fetch_queue #(
    .DEPTH(FIFO_DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .push    (w_push),
    .pushData(w_q_wdata),
    .pop     (w_q_pop),
    .flush   (redirect),
    .full    (w_q_full),
    .empty   (w_q_empty),
    .count   (w_q_count),
    .head    (w_q_head)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (redirect) begin
      if (r_state == DRAIN) w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (fetchEnable) w_state_nxt = FETCH;
        FETCH:   if (!fetchEnable) w_state_nxt = DRAIN;
        DRAIN: begin
          if (fetchEnable)        w_state_nxt = FETCH;
          else if (w_empty_after) w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pc        <= RESET_PC;
      r_align_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_align_err <= redirect & (|redirectTarget[1:0]);
      if (redirect)    r_pc <= align_pc(redirectTarget);
      else if (w_push) r_pc <= r_pc + 32'(INSTR_BYTES);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order scoreboard of expected deliveries.
module tb_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        fetchEnable;
  logic [31:0] pcAddress;
  logic [31:0] pcDataOutput;
  logic        redirect;
  logic [31:0] redirectTarget;
  logic        instrValid;
  logic        instrReady;
  logic [31:0] instr;
  logic [31:0] instrPc;
  logic        alignError;
  logic        busy;

  exp_t sb[$];
  int   n_tests;
  int   n_fail;
  int   n_deliv;
  int   d0;

  fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .FIFO_DEPTH(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .fetchEnable   (fetchEnable),
    .pcAddress     (pcAddress),
    .pcDataOutput  (pcDataOutput),
    .redirect      (redirect),
    .redirectTarget(redirectTarget),
    .instrValid    (instrValid),
    .instrReady    (instrReady),
    .instr         (instr),
    .instrPc       (instrPc),
    .alignError    (alignError),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [31:0] addr);
    case (addr[15:0])
      16'h0000: return 32'h1111_1111;
      16'h0004: return 32'h2222_2222;
      16'h0008: return 32'h3333_3333;
      default:  return {16'hC0DE, addr[15:0]};
    endcase
  endfunction

  assign pcDataOutput = memword(pcAddress);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_stream(input logic [31:0] start, input int n);
    sb.delete();
    for (int i = 0; i < n; i++) begin
      sb.push_back('{pc: start + 32'(i * 4), word: memword(start + 32'(i * 4))});
    end
  endtask

  // Score any handshake completing at the coming edge, then advance one cycle.
  task automatic step();
    exp_t e;
    if (instrValid && instrReady && !redirect && !rst) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $error("FAIL sb_empty: observed instrPc %h expected no delivery", instrPc);
      end else begin
        e = sb.pop_front();
        check("deliv_instr", instr, e.word);
        check("deliv_pc", instrPc, e.pc);
        n_deliv++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; n_deliv = 0;
    rst = 1'b1; fetchEnable = 1'b0; instrReady = 1'b0;
    redirect = 1'b0; redirectTarget = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(instrValid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instrPc", instrPc, 32'd0);
    check("rst_align", 32'(alignError), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pc", pcAddress, 32'd0);
    rst = 1'b0;

    // Streaming: one instruction per cycle.
    expect_stream(32'h0, 16);
    fetchEnable = 1'b1; instrReady = 1'b1;
    step();
    check("s_pc0", pcAddress, 32'h0);
    check("s_valid0", 32'(instrValid), 32'd0);
    step();
    check("s_pc1", pcAddress, 32'h4);
    check("s_head_instr", instr, 32'h1111_1111);
    check("s_head_pc", instrPc, 32'h0);
    step();
    check("s_pc2", pcAddress, 32'h8);
    step();
    step();
    check("s_deliv", 32'(n_deliv), 32'd3);

    // Back-pressure: queue fills to two entries and holds its head.
    instrReady = 1'b0;
    rst = 1'b1; #1; rst = 1'b0; #1;
    expect_stream(32'h0, 16);
    n_deliv = 0;
    repeat (5) step();
    check("bp_pc", pcAddress, 32'h8);
    check("bp_valid", 32'(instrValid), 32'd1);
    check("bp_instr", instr, 32'h1111_1111);
    check("bp_instrPc", instrPc, 32'h0);
    instrReady = 1'b1;
    step();
    check("bp_b2b1", 32'(n_deliv), 32'd1);
    step();
    check("bp_b2b2", 32'(n_deliv), 32'd2);
    step();
    check("bp_b2b3", 32'(n_deliv), 32'd3);

    // Redirect while full with a coincident ready.
    d0 = n_deliv;
    redirect = 1'b1; redirectTarget = 32'h100;
    expect_stream(32'h100, 16);
    step();
    redirect = 1'b0;
    check("rd_valid", 32'(instrValid), 32'd0);
    check("rd_align", 32'(alignError), 32'd0);
    check("rd_pc", pcAddress, 32'h100);
    check("rd_noaccept", 32'(n_deliv), 32'(d0));
    step();
    check("rd_instrPc", instrPc, 32'h100);
    check("rd_instr", instr, 32'hC0DE_0100);
    check("rd_pc_next", pcAddress, 32'h104);
    step();

    // Misaligned redirect target.
    redirect = 1'b1; redirectTarget = 32'h103;
    expect_stream(32'h100, 16);
    step();
    redirect = 1'b0;
    check("al_pulse", 32'(alignError), 32'd1);
    check("al_pc", pcAddress, 32'h100);
    check("al_valid", 32'(instrValid), 32'd0);
    step();
    check("al_clear", 32'(alignError), 32'd0);
    check("al_pc_next", pcAddress, 32'h104);

    // Asynchronous reset with a full queue while fetching.
    instrReady = 1'b0;
    repeat (3) step();
    check("ar_pc_full", pcAddress, 32'h108);
    check("ar_busy_full", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("ar_valid", 32'(instrValid), 32'd0);
    check("ar_pc", pcAddress, 32'h0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_instr", instr, 32'd0);
    rst = 1'b0;
    #1;
    expect_stream(32'h0, 16);
    n_deliv = 0;
    instrReady = 1'b1;
    step();
    check("ar_restart_valid", 32'(instrValid), 32'd0);
    step();
    check("ar_restart_pc", instrPc, 32'h0);
    check("ar_restart_instr", instr, 32'h1111_1111);
    step();

    // Drain: two queued words delivered after fetch is dropped.
    instrReady = 1'b0;
    repeat (3) step();
    check("dr_pc_full", pcAddress, 32'hC);
    fetchEnable = 1'b0;
    d0 = n_deliv;
    step();
    check("dr_busy", 32'(busy), 32'd1);
    check("dr_valid", 32'(instrValid), 32'd1);
    instrReady = 1'b1;
    step();
    step();
    check("dr_count", 32'(n_deliv), 32'(d0 + 2));
    check("dr_busy_low", 32'(busy), 32'd0);
    check("dr_valid_low", 32'(instrValid), 32'd0);
    step();
    check("dr_idle_pc", pcAddress, 32'hC);

    // Wrap at the top of the address space, redirected while idle.
    redirect = 1'b1; redirectTarget = 32'hFFFF_FFFC;
    expect_stream(32'hFFFF_FFFC, 16);
    step();
    redirect = 1'b0;
    check("wr_pc", pcAddress, 32'hFFFF_FFFC);
    check("wr_idle_busy", 32'(busy), 32'd0);
    fetchEnable = 1'b1;
    step();
    step();
    check("wr_pc_wrap", pcAddress, 32'h0);
    check("wr_instrPc", instrPc, 32'hFFFF_FFFC);
    check("wr_instr", instr, 32'hC0DE_FFFC);
    step();
    check("wr_next_instrPc", instrPc, 32'h0);
    check("wr_next_instr", instr, 32'h1111_1111);
    fetchEnable = 1'b0;
    repeat (4) step();
    check("end_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
